gpio_scan_sram_ctrl: RTL and testbench



---
 rtl/gpio_scan_sram_ctrl.sv | 152 +++++++++++++++
 tb/tb_gpio_scan_sram_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_scan_sram_ctrl.sv
// gpio_scan_sram_ctrl: GPIO test-mode scan controller for the SRAM port mux.
// A 112-bit command packet is shifted in serially, and one SRAM access is
// issued on a falling edge of global_csb. Read data is captured and can be
// loaded back into the packet's din fields, then scanned out.
//
// Optional feature: define GPIO_SCAN_ACCESS_COUNT_EN to add access_count[15:0].
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   scan_en, scan_in    shift enable and serial data in (packet MSB first)
//   sram_load           load captured read data into the din fields
//   global_csb          active-low access strobe (falling edge starts access)
//   scan_out            chain MSB
//   sram_sel            selected macro index
//   csb*/web*/addr*/din*/wmask*  SRAM port 0/1 controls
//   dout0, dout1        read data from the selected macro
//   busy                access in flight
//   access_count        (optional) saturating count of enabled accesses
module gpio_scan_sram_ctrl #(
  parameter int unsigned SEL_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WMASK_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   scan_en,
  input  logic                   scan_in,
  input  logic                   sram_load,
  input  logic                   global_csb,
  output logic                   scan_out,
  output logic [SEL_WIDTH-1:0]   sram_sel,
  output logic                   csb0,
  output logic                   web0,
  output logic [ADDR_WIDTH-1:0]  addr0,
  output logic [DATA_WIDTH-1:0]  din0,
  output logic [WMASK_WIDTH-1:0] wmask0,
  output logic                   csb1,
  output logic                   web1,
  output logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  din1,
  output logic [WMASK_WIDTH-1:0] wmask1,
  input  logic [DATA_WIDTH-1:0]  dout0,
  input  logic [DATA_WIDTH-1:0]  dout1,
  output logic                   busy
`ifdef GPIO_SCAN_ACCESS_COUNT_EN
  ,
  output logic [15:0]            access_count
`endif
);

  localparam int unsigned CHAIN_LEN = SEL_WIDTH + 2*(ADDR_WIDTH + DATA_WIDTH + 2 + WMASK_WIDTH);

  // Field order inside each struct matches the packet layout, MSB first.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]  din;
    logic                   csb;
    logic                   web;
    logic [WMASK_WIDTH-1:0] wmask;
  } port_t;

  typedef struct packed {
    logic [SEL_WIDTH-1:0] sel;
    port_t                p0;
    port_t                p1;
  } chain_t;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, CAPTURE = 2'd2} state_t;

  localparam port_t  PORT_RST  = '{addr: '0, din: '0, csb: 1'b1, web: 1'b0, wmask: '0};
  localparam chain_t CHAIN_RST = '{sel: '0, p0: PORT_RST, p1: PORT_RST};

  state_t                state, state_d;
  chain_t                chain, chain_d, snap, view;
  logic                  gcsb_q;
  logic                  start;
  logic [DATA_WIDTH-1:0] dout0_q, dout1_q;

  assign start = gcsb_q && !global_csb && !scan_en && (state == IDLE);

  // Next state and next chain contents; load has priority over shift.
  always_comb begin
    state_d = state;
    chain_d = chain;
    case (state)
      IDLE:    if (start) state_d = ACCESS;
      ACCESS:  state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if ((state == IDLE) && sram_load) begin
      chain_d.p0.din = dout0_q;
      chain_d.p1.din = dout1_q;
    end else if (scan_en) begin
      chain_d = chain_t'({chain[CHAIN_LEN-2:0], scan_in});
    end
  end

  // State, chain, access snapshot, strobes and read capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      chain   <= CHAIN_RST;
      snap    <= CHAIN_RST;
      gcsb_q  <= 1'b1;
      dout0_q <= '0;
      dout1_q <= '0;
      csb0    <= 1'b1;
      csb1    <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state  <= state_d;
      chain  <= chain_d;
      gcsb_q <= global_csb;
      if (start) snap <= chain;
      csb0 <= (state_d == ACCESS) ? chain.p0.csb : 1'b1;
      csb1 <= (state_d == ACCESS) ? chain.p1.csb : 1'b1;
      busy <= (state_d != IDLE);
      if (state == CAPTURE) begin
        if (!snap.p0.csb && snap.p0.web) dout0_q <= dout0;
        if (!snap.p1.csb && snap.p1.web) dout1_q <= dout1;
      end
    end
  end

  // While an access is in flight the SRAM sees the snapshot, so shifting is safe.
  assign view     = (state == IDLE) ? chain : snap;
  assign scan_out = chain[CHAIN_LEN-1];
  assign sram_sel = view.sel;
  assign addr0    = view.p0.addr;
  assign din0     = view.p0.din;
  assign wmask0   = view.p0.wmask;
  assign web0     = csb0 | view.p0.web;
  assign addr1    = view.p1.addr;
  assign din1     = view.p1.din;
  assign wmask1   = view.p1.wmask;
  assign web1     = csb1 | view.p1.web;

`ifdef GPIO_SCAN_ACCESS_COUNT_EN
  // Saturating count of accesses with at least one port enabled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      access_count <= '0;
    end else if ((state == ACCESS) && (!snap.p0.csb || !snap.p1.csb) &&
                 (access_count != 16'hFFFF)) begin
      access_count <= access_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gpio_scan_sram_ctrl.sv
// Scoreboard bench for gpio_scan_sram_ctrl: stimulus pushes expected scan bits,
// expected SRAM accesses and direct checks into queues; a negedge monitor pops
// and compares them against the DUT outputs.
module tb_gpio_scan_sram_ctrl;
  localparam int unsigned CL = 112;

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] a0; logic [31:0] d0; logic c0; logic w0; logic [3:0] m0;
    logic [15:0] a1; logic [31:0] d1; logic c1; logic w1; logic [3:0] m1;
  } pkt_t;

  typedef struct packed { logic [7:0] id; logic [63:0] act; logic [63:0] exp; } chk_t;

  logic clk = 1'b0;
  logic reset_n, scan_en, scan_in, sram_load, global_csb;
  logic scan_out, csb0, web0, csb1, web1, busy;
  logic [3:0]  sram_sel, wmask0, wmask1;
  logic [15:0] addr0, addr1;
  logic [31:0] din0, din1, dout0, dout1;
`ifdef GPIO_SCAN_ACCESS_COUNT_EN
  logic [15:0] access_count;
`endif

  always #5 clk = ~clk;

  gpio_scan_sram_ctrl dut (
    .clk(clk), .reset_n(reset_n), .scan_en(scan_en), .scan_in(scan_in),
    .sram_load(sram_load), .global_csb(global_csb), .scan_out(scan_out),
    .sram_sel(sram_sel), .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0),
    .wmask0(wmask0), .csb1(csb1), .web1(web1), .addr1(addr1), .din1(din1),
    .wmask1(wmask1), .dout0(dout0), .dout1(dout1), .busy(busy)
`ifdef GPIO_SCAN_ACCESS_COUNT_EN
    , .access_count(access_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  pkt_t aq[$];
  logic sq[$];
  chk_t cq[$];

  function automatic logic [31:0] init_val(logic [7:0] k);
    return {k, ~k, k ^ 8'h5A, 8'hC3};
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] m);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [7:0] key_of(logic [3:0] s, logic [15:0] a);
    return {s[1:0], a[5:0]};
  endfunction

  // Environment SRAM: stores contents XOR init_val so unwritten words read init_val.
  logic [31:0] sram_mem [256] = '{default: 32'h0};
  logic [7:0]  k0, k1;
  assign k0 = key_of(sram_sel, addr0);
  assign k1 = key_of(sram_sel, addr1);
  always @(posedge clk) begin
    if (!csb0) begin
      if (web0) dout0 <= sram_mem[k0] ^ init_val(k0);
      else sram_mem[k0] <= merge(sram_mem[k0] ^ init_val(k0), din0, wmask0) ^ init_val(k0);
    end
    if (!csb1) begin
      if (web1) dout1 <= sram_mem[k1] ^ init_val(k1);
      else sram_mem[k1] <= merge(sram_mem[k1] ^ init_val(k1), din1, wmask1) ^ init_val(k1);
    end
  end

  function automatic string name_of(logic [7:0] id);
    case (id)
      8'd0:  return "busy_cycles";
      8'd1:  return "reset_scan_out";
      8'd2:  return "reset_csb0";
      8'd3:  return "reset_csb1";
      8'd4:  return "reset_web0";
      8'd5:  return "reset_web1";
      8'd6:  return "reset_busy";
      8'd7:  return "rd_din0";
      8'd8:  return "rd_din1";
      8'd9:  return "rd_sel";
      8'd10: return "neg_edge_busy";
      8'd11: return "post_rst_csb0";
      8'd12: return "post_rst_csb1";
      8'd13: return "post_rst_busy";
      8'd14: return "post_rst_scan_out";
      8'd15: return "zero_din0";
      8'd16: return "zero_din1";
      8'd17: return "acc_pending";
      8'd18: return "scan_pending";
      8'd19: return "reset_sel";
      default: return "check";
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic cmp(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  chk_t mc;
  pkt_t me;
  always @(negedge clk) begin
    while (cq.size() > 0) begin
      mc = cq.pop_front();
      cmp(name_of(mc.id), mc.act, mc.exp);
    end
    if (scan_en === 1'b1) begin
      if (sq.size() == 0) cmp("scan_unexpected", 64'd1, 64'd0);
      else cmp("scan_out", 64'(scan_out), 64'(sq.pop_front()));
    end
    if (csb0 === 1'b0 || csb1 === 1'b0) begin
      if (aq.size() == 0) cmp("access_unexpected", 64'd1, 64'd0);
      else begin
        me = aq.pop_front();
        cmp("acc_sel",    64'(sram_sel), 64'(me.sel));
        cmp("acc_csb0",   64'(csb0),     64'(me.c0));
        cmp("acc_web0",   64'(web0),     64'(me.c0 | me.w0));
        cmp("acc_addr0",  64'(addr0),    64'(me.a0));
        cmp("acc_din0",   64'(din0),     64'(me.d0));
        cmp("acc_wmask0", 64'(wmask0),   64'(me.m0));
        cmp("acc_csb1",   64'(csb1),     64'(me.c1));
        cmp("acc_web1",   64'(web1),     64'(me.c1 | me.w1));
        cmp("acc_addr1",  64'(addr1),    64'(me.a1));
        cmp("acc_din1",   64'(din1),     64'(me.d1));
        cmp("acc_wmask1", 64'(wmask1),   64'(me.m1));
      end
    end
  end

  // ---------------- reference model + stimulus ----------------
  pkt_t        m_chain, cap;
  logic [31:0] m_dq0, m_dq1;
  logic [31:0] ref_mem [256];
  pkt_t        rst_pkt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_chk(logic [7:0] id, logic [63:0] a, logic [63:0] e);
    cq.push_back('{id: id, act: a, exp: e});
  endtask

  task automatic shift_bit(logic b);
    sq.push_back(m_chain[CL-1]);
    cap     = pkt_t'({cap[CL-2:0], scan_out});
    scan_en = 1'b1;
    scan_in = b;
    m_chain = pkt_t'({m_chain[CL-2:0], b});
    tick();
  endtask

  task automatic shift_pkt(pkt_t p);
    for (int i = CL - 1; i >= 0; i--) shift_bit(p[i]);
    scan_en = 1'b0;
  endtask

  // Expected effect of one access issued from the current chain fields.
  task automatic model_access(pkt_t f, logic upd_dq);
    logic [7:0] a = key_of(f.sel, f.a0);
    logic [7:0] b = key_of(f.sel, f.a1);
    if (!f.c0 || !f.c1) aq.push_back(f);
    if (upd_dq && !f.c0 && f.w0) m_dq0 = ref_mem[a];
    if (upd_dq && !f.c1 && f.w1) m_dq1 = ref_mem[b];
    if (!f.c0 && !f.w0) ref_mem[a] = merge(ref_mem[a], f.d0, f.m0);
    if (!f.c1 && !f.w1) ref_mem[b] = merge(ref_mem[b], f.d1, f.m1);
  endtask

  task automatic do_access(int hold, logic shift_during);
    int bc = 0;
    model_access(m_chain, 1'b1);
    scan_en    = 1'b0;
    global_csb = 1'b0;
    tick();
    if (busy) bc++;
    if (shift_during) begin
      shift_bit(1'($urandom)); if (busy) bc++;
      shift_bit(1'($urandom)); if (busy) bc++;
      scan_en = 1'b0;
    end
    for (int i = 1; i < hold; i++) begin tick(); if (busy) bc++; end
    global_csb = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); if (busy) bc++; end
    push_chk(8'd0, 64'(bc), 64'd2);
  endtask

  task automatic do_load(logic with_scan);
    if (with_scan) begin
      sq.push_back(m_chain[CL-1]);
      scan_en = 1'b1;
      scan_in = 1'($urandom);
    end
    sram_load = 1'b1;
    tick();
    sram_load = 1'b0;
    scan_en   = 1'b0;
    m_chain.d0 = m_dq0;
    m_chain.d1 = m_dq1;
  endtask

  function automatic pkt_t rand_pkt();
    pkt_t p;
    p = pkt_t'({$urandom, $urandom, $urandom, $urandom});
    p.sel = 4'($urandom_range(0, 3));
    return p;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    rst_pkt = '0; rst_pkt.c0 = 1'b1; rst_pkt.c1 = 1'b1;
    m_chain = rst_pkt; cap = '0; m_dq0 = '0; m_dq1 = '0;
    reset_n = 1'b0; scan_en = 1'b0; scan_in = 1'b0; sram_load = 1'b0; global_csb = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    push_chk(8'd1, 64'(scan_out), 64'd0);
    push_chk(8'd2, 64'(csb0), 64'd1);
    push_chk(8'd3, 64'(csb1), 64'd1);
    push_chk(8'd4, 64'(web0), 64'd1);
    push_chk(8'd5, 64'(web1), 64'd1);
    push_chk(8'd6, 64'(busy), 64'd0);
    push_chk(8'd19, 64'(sram_sel), 64'd0);
    tick();

    // Writes: port0 addr1 <= 5, then port1 addr2 <= 0x28; then read both back.
    shift_pkt('{sel: 4'h3, a0: 16'd1, d0: 32'h5, c0: 1'b0, w0: 1'b0, m0: 4'hF,
                a1: 16'd0, d1: 32'd0, c1: 1'b1, w1: 1'b1, m1: 4'hF});
    do_access(1, 1'b0);
    shift_pkt('{sel: 4'h3, a0: 16'd0, d0: 32'd0, c0: 1'b1, w0: 1'b1, m0: 4'hF,
                a1: 16'd2, d1: 32'h28, c1: 1'b0, w1: 1'b0, m1: 4'hF});
    do_access(1, 1'b0);
    shift_pkt('{sel: 4'h3, a0: 16'd1, d0: 32'd0, c0: 1'b0, w0: 1'b1, m0: 4'hF,
                a1: 16'd2, d1: 32'd0, c1: 1'b0, w1: 1'b1, m1: 4'hF});
    do_access(1, 1'b0);
    do_load(1'b0);
    shift_pkt(rand_pkt());
    push_chk(8'd7, 64'(cap.d0), 64'h5);
    push_chk(8'd8, 64'(cap.d1), 64'h28);
    push_chk(8'd9, 64'(cap.sel), 64'h3);

    // global_csb held low five cycles, then load together with scan_en.
    shift_pkt('{sel: 4'h3, a0: 16'd2, d0: 32'd0, c0: 1'b0, w0: 1'b1, m0: 4'h0,
                a1: 16'd1, d1: 32'd0, c1: 1'b0, w1: 1'b1, m1: 4'h0});
    do_access(5, 1'b0);
    do_load(1'b1);
    shift_pkt(rand_pkt());

    // Falling edge while shifting: no access, and no access later while held low.
    global_csb = 1'b0;
    for (int i = 0; i < 3; i++) shift_bit(1'($urandom));
    scan_en = 1'b0;
    tick(); tick();
    global_csb = 1'b1;
    tick();
    push_chk(8'd10, 64'(busy), 64'd0);

    // Reset during CAPTURE discards the in-flight read.
    shift_pkt('{sel: 4'h3, a0: 16'd1, d0: 32'd0, c0: 1'b0, w0: 1'b1, m0: 4'h0,
                a1: 16'd2, d1: 32'd0, c1: 1'b0, w1: 1'b1, m1: 4'h0});
    model_access(m_chain, 1'b0);
    global_csb = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; global_csb = 1'b1;
    m_chain = rst_pkt; m_dq0 = '0; m_dq1 = '0;
    push_chk(8'd11, 64'(csb0), 64'd1);
    push_chk(8'd12, 64'(csb1), 64'd1);
    push_chk(8'd13, 64'(busy), 64'd0);
    push_chk(8'd14, 64'(scan_out), 64'd0);
    tick();
    do_load(1'b0);
    shift_pkt(rand_pkt());
    push_chk(8'd15, 64'(cap.d0), 64'd0);
    push_chk(8'd16, 64'(cap.d1), 64'd0);

    // Randomized transactions.
    for (int n = 0; n < 12; n++) begin
      shift_pkt(rand_pkt());
      do_access($urandom_range(1, 3), 1'($urandom));
      do_load(1'($urandom));
    end
    shift_pkt(rand_pkt());

    tick();
    push_chk(8'd17, 64'(aq.size()), 64'd0);
    push_chk(8'd18, 64'(sq.size()), 64'd0);
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
